// File: rtl/verificador_nonce.sv
// Nonce checker: mixes each candidate with a header over ROUNDS rounds and stops on a target hit.
// Latency ROUNDS+3 cycles per attempt; valid=0 for one cycle requests the next nonce, fin=1 freezes the generator.
// Optional macro VERIFICADOR_TIMEOUT_EN ends the search unsuccessfully after MAX_ATTEMPTS candidates.
module verificador_nonce #(
   parameter int ROUNDS       = 8,
   parameter int TARGET_W     = 16,
   parameter int MAX_ATTEMPTS = 1024
) (
   input  logic                clk,
   input  logic                reset_L,
   input  logic                start,
   input  logic [31:0]         header,
   input  logic [TARGET_W-1:0] target,
   input  logic [31:0]         nonce,
   output logic                valid,
   output logic                fin,
   output logic                found,
   output logic [31:0]         nonce_found,
   output logic [31:0]         hash_out,
   output logic [31:0]         attempts
);

`ifdef VERIFICADOR_TIMEOUT_EN
   localparam bit TIMEOUT_EN = 1'b1;
`else
   localparam bit TIMEOUT_EN = 1'b0;
`endif
   localparam logic [5:0]  LAST_ROUND = 6'(ROUNDS - 1);
   localparam logic [31:0] GOLDEN     = 32'h9E3779B9;
   localparam logic [31:0] MAX_ATT    = 32'(MAX_ATTEMPTS);

   typedef enum logic [2:0] {S_IDLE, S_REQ, S_LOAD, S_ROUND, S_CHECK, S_DONE} state_t;
   state_t state, state_nxt;

   logic [31:0] h;
   logic [31:0] cand;
   logic [31:0] attempts_inc;
   logic [5:0]  rcnt;
   logic        hit;
   logic        timeout;

   assign attempts_inc = (attempts == 32'hFFFF_FFFF) ? attempts : attempts + 32'd1;
   assign hit          = (h[31 -: TARGET_W] <= target);
   assign timeout      = TIMEOUT_EN && !hit && ((attempts + 32'd1) == MAX_ATT);

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) state <= S_IDLE;
      else          state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      valid     = 1'b1;
      case (state)
         S_IDLE:  if (start) state_nxt = S_REQ;
         S_REQ: begin
            valid     = 1'b0;
            state_nxt = S_LOAD;
         end
         S_LOAD:  state_nxt = S_ROUND;
         S_ROUND: if (rcnt == LAST_ROUND) state_nxt = S_CHECK;
         S_CHECK: state_nxt = (hit || timeout) ? S_DONE : S_REQ;
         S_DONE:  if (!start) state_nxt = S_IDLE;
         default: state_nxt = S_IDLE;
      endcase
   end

   // The candidate is captured in LOAD so later activity on the nonce bus cannot leak into the result.
   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         h           <= '0;
         cand        <= '0;
         rcnt        <= '0;
         attempts    <= '0;
         nonce_found <= '0;
         hash_out    <= '0;
         found       <= 1'b0;
         fin         <= 1'b0;
      end else begin
         case (state)
            S_IDLE: if (start) attempts <= '0;
            S_LOAD: begin
               h    <= header ^ nonce;
               cand <= nonce;
               rcnt <= '0;
            end
            S_ROUND: begin
               h    <= {h[26:0], h[31:27]} + (h ^ (GOLDEN + {26'd0, rcnt}));
               rcnt <= rcnt + 6'd1;
            end
            S_CHECK: begin
               attempts <= attempts_inc;
               if (hit) begin
                  nonce_found <= cand;
                  hash_out    <= h;
                  found       <= 1'b1;
                  fin         <= 1'b1;
               end else if (timeout) begin
                  found <= 1'b0;
                  fin   <= 1'b1;
               end
            end
            S_DONE: if (!start) fin <= 1'b0;
            default: ;
         endcase
      end
   end

endmodule

// File: tb/tb_verificador_nonce.sv
// Bench for verificador_nonce: generator stub, reference hash model and a scoreboard checked at each fin rise.
module tb_verificador_nonce;
   localparam int ROUNDS = 8;
   localparam int TW     = 16;
   localparam int MAXA   = 4;
`ifdef VERIFICADOR_TIMEOUT_EN
   localparam bit TO_EN = 1'b1;
`else
   localparam bit TO_EN = 1'b0;
`endif

   logic          clk;
   logic          reset_L;
   logic          start;
   logic [31:0]   header;
   logic [TW-1:0] target;
   logic [31:0]   nonce;
   logic          valid;
   logic          fin;
   logic          found;
   logic [31:0]   nonce_found;
   logic [31:0]   hash_out;
   logic [31:0]   attempts;

   verificador_nonce #(.ROUNDS(ROUNDS), .TARGET_W(TW), .MAX_ATTEMPTS(MAXA)) dut (
      .clk(clk), .reset_L(reset_L), .start(start), .header(header), .target(target),
      .nonce(nonce), .valid(valid), .fin(fin), .found(found), .nonce_found(nonce_found),
      .hash_out(hash_out), .attempts(attempts)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h, expected %h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] ref_hash(input logic [31:0] hdr, input logic [31:0] n);
      logic [31:0] x;
      x = hdr ^ n;
      for (int r = 0; r < ROUNDS; r++)
         x = ((x << 5) | (x >> 27)) + (x ^ (32'h9E3779B9 + 32'(r)));
      return x;
   endfunction

   function automatic bit ref_hit(input logic [31:0] hs, input logic [TW-1:0] tgt);
      return (hs >> (32 - TW)) <= 32'(tgt);
   endfunction

   typedef struct {
      logic        found;
      logic [31:0] nf;
      logic [31:0] hs;
      logic [31:0] att;
   } exp_t;

   exp_t        exp_q[$];
   logic [31:0] gen_q[$];
   logic [31:0] last_nf    = 32'd0;
   logic [31:0] last_hs    = 32'd0;
   logic        last_found = 1'b0;

   // Generator stub: new nonce on a request, held through LOAD, scrambled otherwise.
   bit keep = 1'b0;
   always @(negedge clk) begin
      if (!valid) begin
         if (gen_q.size() > 0) nonce = gen_q.pop_front();
         else                  nonce = $urandom;
         keep = 1'b1;
      end else if (keep) begin
         keep = 1'b0;
      end else begin
         nonce = $urandom;
      end
   end

   // Monitor: request spacing and scoreboard comparison at every fin rise.
   longint cyc      = 0;
   longint last_req = -1;
   int     reqs     = 0;
   logic   fin_d    = 1'b0;
   always @(posedge clk) cyc++;
   always @(negedge clk) begin
      exp_t e;
      if (!reset_L) begin
         reqs = 0; last_req = -1; fin_d = 1'b0;
      end else begin
         if (!valid) begin
            if (last_req >= 0) chk("req_spacing", 32'(cyc - last_req), 32'd11);
            last_req = cyc;
            reqs++;
         end
         if (fin && !fin_d) begin
            if (exp_q.size() == 0) begin
               chk("fin_without_search", {31'd0, fin}, 32'd0);
            end else begin
               e = exp_q.pop_front();
               chk("found",       {31'd0, found}, {31'd0, e.found});
               chk("nonce_found", nonce_found, e.nf);
               chk("hash_out",    hash_out, e.hs);
               chk("attempts",    attempts, e.att);
               chk("req_count",   32'(reqs), e.att);
            end
            reqs = 0; last_req = -1;
         end
         fin_d = fin;
      end
   end

   task automatic do_reset();
      @(negedge clk);
      reset_L = 1'b0;
      start   = 1'b0;
      @(negedge clk);
      reset_L = 1'b1;
      gen_q.delete();
      last_nf = 32'd0; last_hs = 32'd0; last_found = 1'b0;
   endtask

   // Builds the nonce list, predicts the outcome, then runs the search through DONE and back to IDLE.
   task automatic do_search(input logic [31:0] hdr, input logic [TW-1:0] tgt,
                            input bit use_forced, input logic [31:0] forced, input int hold);
      int          att;
      int          edges;
      int          bad;
      bit          done;
      logic [31:0] n;
      logic [31:0] hs;
      exp_t        e;
      att = 0; done = 1'b0;
      gen_q.delete();
      for (int i = 0; i < 300 && !done; i++) begin
         n = (use_forced && i == 2) ? forced : $urandom;
         gen_q.push_back(n);
         hs  = ref_hash(hdr, n);
         att = i + 1;
         if (ref_hit(hs, tgt)) begin
            last_nf = n; last_hs = hs; last_found = 1'b1; done = 1'b1;
         end else if (TO_EN && att == MAXA) begin
            last_found = 1'b0; done = 1'b1;
         end
      end
      e.found = last_found; e.nf = last_nf; e.hs = last_hs; e.att = 32'(att);
      exp_q.push_back(e);
      header = hdr;
      target = tgt;
      @(negedge clk);
      start = 1'b1;
      edges = 0;
      while (!fin && edges < 4000) begin
         @(posedge clk);
         edges++;
         @(negedge clk);
      end
      if (!fin) begin
         chk("fin_wait", {31'd0, fin}, 32'd1);
         exp_q.delete();
         do_reset();
         return;
      end
      chk("fin_latency", 32'(edges), 32'(11 * att + 1));
      bad = 0;
      repeat (hold) begin
         @(negedge clk);
         if (fin !== 1'b1 || valid !== 1'b1) bad++;
      end
      chk("done_hold_stable", 32'(bad), 32'd0);
      start = 1'b0;
      @(negedge clk);
      chk("fin_drop", {31'd0, fin}, 32'd0);
      gen_q.delete();
   endtask

   initial begin
      logic [31:0] fn;
      logic [31:0] n;
      bit          got;
      reset_L = 1'b1;
      start   = 1'b0;
      header  = '0;
      target  = '0;
      nonce   = '0;
      #1 reset_L = 1'b0;
      repeat (2) @(negedge clk);
      chk("rst_valid",       {31'd0, valid}, 32'd1);
      chk("rst_fin",         {31'd0, fin}, 32'd0);
      chk("rst_found",       {31'd0, found}, 32'd0);
      chk("rst_attempts",    attempts, 32'd0);
      chk("rst_nonce_found", nonce_found, 32'd0);
      chk("rst_hash_out",    hash_out, 32'd0);
      reset_L = 1'b1;
      @(negedge clk);

      // First candidate always hits with an all-ones target.
      do_search(32'd0, '1, 1'b0, 32'd0, 1);

      repeat (6) do_search($urandom, TW'(16'h1000 + $urandom_range(0, 16'h3000)), 1'b0, 32'd0, 1);

      // Find a nonce that hits target 0 for header DEADBEEF and place it third.
      got = 1'b0;
      fn  = $urandom;
      for (int i = 0; i < (1 << 22) && !got; i++) begin
         if (ref_hit(ref_hash(32'hDEADBEEF, fn), '0)) got = 1'b1;
         else fn = fn + 32'd1;
      end
      chk("model_found_hit", {31'd0, got}, 32'd1);
      do_search(32'hDEADBEEF, '0, 1'b1, fn, 20);
      do_search($urandom, '1, 1'b0, 32'd0, 1);

      // Asynchronous reset in the middle of ROUND.
      header = $urandom;
      target = '0;
      gen_q.delete();
      repeat (4) gen_q.push_back($urandom);
      @(negedge clk);
      start = 1'b1;
      repeat (6) @(posedge clk);
      #2 reset_L = 1'b0;
      #1;
      chk("midrst_valid",       {31'd0, valid}, 32'd1);
      chk("midrst_fin",         {31'd0, fin}, 32'd0);
      chk("midrst_attempts",    attempts, 32'd0);
      chk("midrst_nonce_found", nonce_found, 32'd0);
      chk("midrst_hash_out",    hash_out, 32'd0);
      start = 1'b0;
      repeat (2) @(negedge clk);
      reset_L = 1'b1;
      gen_q.delete();
      last_nf = 32'd0; last_hs = 32'd0; last_found = 1'b0;
      do_search($urandom, '1, 1'b0, 32'd0, 1);

      if (TO_EN) begin
         do_search($urandom, '0, 1'b0, 32'd0, 1);
      end else begin
         header = 32'hDEADBEEF;
         target = '0;
         gen_q.delete();
         for (int i = 0; i < 100; i++) begin
            n = $urandom;
            while (ref_hit(ref_hash(32'hDEADBEEF, n), '0)) n = $urandom;
            gen_q.push_back(n);
         end
         @(negedge clk);
         start = 1'b1;
         repeat (1101) @(posedge clk);
         @(negedge clk);
         chk("no_timeout_fin",      {31'd0, fin}, 32'd0);
         chk("no_timeout_attempts", attempts, 32'd100);
         do_reset();
      end

      repeat (3) @(negedge clk);
      chk("scoreboard_drained", 32'(exp_q.size()), 32'd0);
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

   initial begin
      #5_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $display("Result: errors=%0d of %0d checks", errors + 1, checks + 1);
      $fatal(1);
   end

endmodule
